// File: rtl/pipe_delay_checker.sv
// Golden-history checker for a two-stage register pipeline: b must equal a delayed 1 clock, c must equal a delayed DEPTH clocks.
// Optional macro PIPE_CHK_STOP_ON_ERR_EN: halt on the first mismatch and keep a snapshot of the failing values.
module pipe_delay_checker #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             b_err,
   output logic             c_err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [15:0]      chk_cnt,
   output logic [1:0]       state,
   output logic             pass
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WARMUP = 2'd1;
   localparam logic [1:0] CHECK  = 2'd2;
   localparam logic [1:0] HALT   = 2'd3;

   localparam logic [3:0] WARM_LAST = 4'(DEPTH - 1);

   logic [WIDTH-1:0] h [DEPTH];
   logic [3:0]       wcnt;
   logic             b_mis;
   logic             c_mis;
   logic [ERR_W-1:0] err_inc;

   // Expected values come from the history before this edge's shift.
   assign b_mis   = (b != h[0]);
   assign c_mis   = (c != h[DEPTH-1]);
   assign err_inc = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : err_cnt + ERR_W'(1);
   assign pass    = (state == CHECK) && (err_cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) h[k] <= '0;
      end else if (state != IDLE) begin
         h[0] <= a;
         for (int k = 1; k < DEPTH; k++) h[k] <= h[k-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         wcnt    <= '0;
         b_err   <= 1'b0;
         c_err   <= 1'b0;
         err_cnt <= '0;
         chk_cnt <= '0;
      end else if (clear) begin
         state   <= enable ? WARMUP : IDLE;
         wcnt    <= '0;
         b_err   <= 1'b0;
         c_err   <= 1'b0;
         err_cnt <= '0;
         chk_cnt <= '0;
      end else if (!enable) begin
         state <= IDLE;
         b_err <= 1'b0;
         c_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= WARMUP;
               wcnt  <= '0;
               b_err <= 1'b0;
               c_err <= 1'b0;
            end
            WARMUP: begin
               b_err <= 1'b0;
               c_err <= 1'b0;
               if (wcnt == WARM_LAST) state <= CHECK;
               else                   wcnt  <= wcnt + 4'd1;
            end
            CHECK: begin
               chk_cnt <= chk_cnt + 16'd1;
               b_err   <= b_mis;
               c_err   <= c_mis;
               if (b_mis || c_mis) begin
                  err_cnt <= err_inc;
`ifdef PIPE_CHK_STOP_ON_ERR_EN
                  state   <= HALT;
`endif
               end
            end
            default: begin
`ifdef PIPE_CHK_STOP_ON_ERR_EN
               // HALT freezes counters and error flags until clear, enable=0 or reset.
               state <= HALT;
`else
               state <= IDLE;
               b_err <= 1'b0;
               c_err <= 1'b0;
`endif
            end
         endcase
      end
   end

`ifdef PIPE_CHK_STOP_ON_ERR_EN
   // Failing expected/actual values, captured on the edge that enters HALT.
   logic [WIDTH-1:0] snap_b_exp;
   logic [WIDTH-1:0] snap_c_exp;
   logic [WIDTH-1:0] snap_b;
   logic [WIDTH-1:0] snap_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_b_exp <= '0;
         snap_c_exp <= '0;
         snap_b     <= '0;
         snap_c     <= '0;
      end else if (!clear && enable && state == CHECK && (b_mis || c_mis)) begin
         snap_b_exp <= h[0];
         snap_c_exp <= h[DEPTH-1];
         snap_b     <= b;
         snap_c     <= c;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_delay_checker.sv
// Directed bench for pipe_delay_checker: an in-bench two-stage pipe (correct, blocking-collapsed, or b forced) feeds the checker.
module tb_pipe_delay_checker;

`ifdef PIPE_CHK_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WARMUP = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_HALT   = 2'd3;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        clear;
   logic [3:0]  a;
   logic [3:0]  b;
   logic [3:0]  c;
   logic [3:0]  r1;
   logic [3:0]  r2;
   logic        blk;
   logic        force_b;

   logic        b_err, c_err, pass;
   logic [7:0]  err_cnt;
   logic [15:0] chk_cnt;
   logic [1:0]  state;

   logic        s_b_err, s_c_err, s_pass;
   logic [1:0]  s_err_cnt;
   logic [15:0] s_chk_cnt;
   logic [1:0]  s_state;

   int vectors;
   int miscompares;

   pipe_delay_checker #(.WIDTH(4), .DEPTH(2), .ERR_W(8)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .a(a), .b(b), .c(c),
      .b_err(b_err), .c_err(c_err), .err_cnt(err_cnt), .chk_cnt(chk_cnt),
      .state(state), .pass(pass)
   );

   pipe_delay_checker #(.WIDTH(4), .DEPTH(2), .ERR_W(2)) u_dut_sat (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .a(a), .b(b), .c(c),
      .b_err(s_b_err), .c_err(s_c_err), .err_cnt(s_err_cnt), .chk_cnt(s_chk_cnt),
      .state(s_state), .pass(s_pass)
   );

   // Clock and the observed pipeline.
   initial clk = 1'b0;
   always #50 clk = ~clk;

   always @(posedge clk) begin
      r1 <= a;
      r2 <= r1;
   end

   assign b = force_b ? 4'h0 : r1;
   assign c = blk ? r1 : r2;

   task automatic tick();
      @(posedge clk);
      #20;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b1; enable = 1'b0; clear = 1'b0; a = 4'h0;
      blk = 1'b0; force_b = 1'b0;
      #30;
      chk("rst_state", 32'(state), 32'(S_IDLE));
      chk("rst_err_cnt", 32'(err_cnt), 0);
      chk("rst_chk_cnt", 32'(chk_cnt), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_flags", 32'({b_err, c_err}), 0);

      // Correct pipe.
      reset = 1'b0; enable = 1'b1; a = 4'h3;
      tick(); chk("nb_warm1", 32'(state), 32'(S_WARMUP));
      a = 4'h7;
      tick(); chk("nb_warm2", 32'(state), 32'(S_WARMUP));
      a = 4'hf;
      tick(); chk("nb_check", 32'(state), 32'(S_CHECK));
      chk("nb_pass0", 32'(pass), 1);
      chk("nb_chk0", 32'(chk_cnt), 0);
      a = 4'ha;
      tick(); chk("nb_flags1", 32'({b_err, c_err}), 0);
      a = 4'h2;
      tick(); chk("nb_flags2", 32'({b_err, c_err}), 0);
      tick(); chk("nb_flags3", 32'({b_err, c_err}), 0);
      chk("nb_err_cnt", 32'(err_cnt), 0);
      chk("nb_chk_cnt", 32'(chk_cnt), 3);
      chk("nb_pass", 32'(pass), 1);

      // enable low: IDLE, counters hold.
      enable = 1'b0;
      tick(); chk("dis_state", 32'(state), 32'(S_IDLE));
      chk("dis_chk_hold", 32'(chk_cnt), 3);
      chk("dis_pass", 32'(pass), 0);

      // Blocking pipe: c has 1-cycle latency.
      enable = 1'b1; clear = 1'b1; blk = 1'b1; a = 4'h3;
      tick(); chk("blk_warm", 32'(state), 32'(S_WARMUP));
      chk("blk_clr_chk", 32'(chk_cnt), 0);
      clear = 1'b0; a = 4'h7;
      tick(); chk("blk_warm2", 32'(state), 32'(S_WARMUP));
      a = 4'hf;
      tick(); chk("blk_check", 32'(state), 32'(S_CHECK));
      a = 4'ha;
      tick(); chk("blk_flags1", 32'({b_err, c_err}), 32'(2'b01));
      chk("blk_err1", 32'(err_cnt), 1);
      chk("blk_state1", 32'(state), 32'(STOP ? S_HALT : S_CHECK));
      a = 4'h2;
      tick(); chk("blk_flags2", 32'({b_err, c_err}), 32'(2'b01));
      chk("blk_err2", 32'(err_cnt), STOP ? 1 : 2);
      tick(); chk("blk_flags3", 32'({b_err, c_err}), 32'(2'b01));
      chk("blk_err3", 32'(err_cnt), STOP ? 1 : 3);
      chk("blk_chk_cnt", 32'(chk_cnt), STOP ? 1 : 3);
      chk("blk_pass", 32'(pass), 0);
      enable = 1'b0;
      tick(); chk("blk_idle", 32'(state), 32'(S_IDLE));
      chk("blk_idle_flags", 32'({b_err, c_err}), 0);
      chk("blk_idle_err", 32'(err_cnt), STOP ? 1 : 3);
      enable = 1'b1;
      tick(); chk("blk_rewarm", 32'(state), 32'(S_WARMUP));

      // b forced to 0 while a holds 5: err_cnt saturation.
      blk = 1'b0; a = 4'h5; force_b = 1'b1; clear = 1'b1;
      tick(); chk("sat_clr_err", 32'(err_cnt), 0);
      chk("sat_clr_err_s", 32'(s_err_cnt), 0);
      clear = 1'b0;
      tick();
      tick(); chk("sat_check", 32'(state), 32'(S_CHECK));
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("sat_b_err", 32'(b_err), 1);
         chk("sat_c_err", 32'(c_err), 0);
         chk("sat_err_s", 32'(s_err_cnt), STOP ? 1 : ((i + 1 > 3) ? 3 : i + 1));
      end
      chk("sat_err_wide", 32'(err_cnt), STOP ? 1 : 6);
      chk("sat_chk_cnt", 32'(chk_cnt), STOP ? 1 : 6);
      chk("sat_state", 32'(state), 32'(STOP ? S_HALT : S_CHECK));

      // clear mid-CHECK with err_cnt at 2.
      clear = 1'b1;
      tick(); clear = 1'b0;
      tick();
      tick(); chk("clr_check", 32'(state), 32'(S_CHECK));
      tick(); chk("clr_err1", 32'(err_cnt), 1);
      tick(); chk("clr_err2", 32'(err_cnt), STOP ? 1 : 2);
      force_b = 1'b0; clear = 1'b1;
      tick(); chk("clr_err0", 32'(err_cnt), 0);
      chk("clr_chk0", 32'(chk_cnt), 0);
      chk("clr_state", 32'(state), 32'(S_WARMUP));
      chk("clr_flags", 32'({b_err, c_err}), 0);
      clear = 1'b0;
      tick(); chk("clr_warm", 32'(state), 32'(S_WARMUP));
      tick(); chk("clr_recheck", 32'(state), 32'(S_CHECK));
      a = 4'h9;
      tick(); chk("clr_pass", 32'(pass), 1);
      chk("clr_chk1", 32'(chk_cnt), 1);
      tick(); chk("clr_chk2", 32'(chk_cnt), 2);

      // Asynchronous reset 20 ns after an edge in CHECK.
      reset = 1'b1;
      #1;
      chk("arst_state", 32'(state), 32'(S_IDLE));
      chk("arst_pass", 32'(pass), 0);
      chk("arst_chk", 32'(chk_cnt), 0);
      chk("arst_err", 32'(err_cnt), 0);
      #20 reset = 1'b0;
      tick(); chk("arst_warm", 32'(state), 32'(S_WARMUP));
      a = 4'h1;
      tick(); chk("arst_warm2", 32'(state), 32'(S_WARMUP));
      a = 4'h6;
      tick(); chk("arst_check", 32'(state), 32'(S_CHECK));
      a = 4'h3;
      tick(); chk("arst_flags", 32'({b_err, c_err}), 0);
      chk("arst_pass_on", 32'(pass), 1);
      chk("arst_chk1", 32'(chk_cnt), 1);

      // enable=0 together with clear: IDLE with counters zeroed.
      enable = 1'b0; clear = 1'b1;
      tick(); chk("enclr_state", 32'(state), 32'(S_IDLE));
      chk("enclr_chk", 32'(chk_cnt), 0);
      clear = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
